// File: rtl/dual_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dual_pipe_stall_ctrl
//  Purpose  : Buffers two pipeline tails in 2-entry lanes, merges them onto a
//             single round-robin output, and drives the global stall/flush.
//  Revision : 1.0 - initial release
// ============================================================================
module dual_pipe_stall_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_valid_2,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              flush_req,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Lane 0 is pipeline 1, lane 1 is pipeline 2; entry 0 is always the head.
    logic [1:0]        r_cnt [2];
    logic [DATA_W-1:0] r_mem [2][2];
    logic              r_last_grant;
    logic              r_flush;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic [DATA_W-1:0] w_in_data [2];
    logic [1:0]        w_in_valid;
    logic [1:0]        w_elig;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic              w_stall;
    logic              w_grant;
    logic              w_xfer;

    assign w_in_data[0] = in_data_1;
    assign w_in_data[1] = in_data_2;
    assign w_in_valid   = {in_valid_2, in_valid_1};

    assign w_elig[0] = (r_cnt[0] != 2'd0);
    assign w_elig[1] = (r_cnt[1] != 2'd0);
    assign w_stall   = (r_cnt[0] == 2'd2) | (r_cnt[1] == 2'd2);

    // On a tie the lane that did not win the last transfer gets the port.
    assign w_grant   = (w_elig[0] & w_elig[1]) ? ~r_last_grant : w_elig[1];
    assign out_valid = (|w_elig) & ~flush_req;
    assign w_xfer    = out_valid & out_ready;

    assign w_push = w_in_valid & {2{~w_stall & ~flush_req}};
    assign w_pop  = {w_xfer & w_grant, w_xfer & ~w_grant};

    assign out_data     = out_valid ? r_mem[w_grant][0] : '0;
    assign out_src      = out_valid & w_grant;
    assign stall        = w_stall;
    assign flush        = r_flush;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                r_cnt[k]    <= 2'd0;
                r_mem[k][0] <= '0;
                r_mem[k][1] <= '0;
            end else if (flush_req) begin
                r_cnt[k] <= 2'd0;
            end else begin
                case ({w_push[k], w_pop[k]})
                    2'b10: begin
                        r_mem[k][r_cnt[k][0]] <= w_in_data[k];
                        r_cnt[k]              <= r_cnt[k] + 2'd1;
                    end
                    2'b01: begin
                        r_mem[k][0] <= r_mem[k][1];
                        r_cnt[k]    <= r_cnt[k] - 2'd1;
                    end
                    2'b11: begin
                        // Push and pop together only happens with one entry held.
                        r_mem[k][0] <= w_in_data[k];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant   <= 1'b1;
            r_flush        <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_flush <= flush_req;
            if (w_xfer) begin
                r_last_grant <= w_grant;
            end
            if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_pipe_stall_ctrl
//  Purpose  : Scoreboard bench for dual_pipe_stall_ctrl with a queue-based
//             reference model; a second narrow-counter instance covers saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dual_pipe_stall_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid_1 = 1'b0, in_valid_2 = 1'b0;
    logic [DW-1:0] in_data_1 = '0, in_data_2 = '0;
    logic          flush_req = 1'b0, out_ready = 1'b0;
    logic          out_valid, out_src, stall, flush;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cycles;

    logic          reset_b = 1'b0;
    logic          in_valid_1_b = 1'b0;
    logic [DW-1:0] in_data_1_b = '0;
    logic          out_valid_b, out_src_b, stall_b, flush_b;
    logic [DW-1:0] out_data_b;
    logic [3:0]    stall_cycles_b;

    dual_pipe_stall_ctrl #(.DATA_W(DW), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid_1(in_valid_1), .in_data_1(in_data_1),
        .in_valid_2(in_valid_2), .in_data_2(in_data_2),
        .flush_req(flush_req), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .stall(stall), .flush(flush), .stall_cycles(stall_cycles)
    );

    dual_pipe_stall_ctrl #(.DATA_W(DW), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset_b),
        .in_valid_1(in_valid_1_b), .in_data_1(in_data_1_b),
        .in_valid_2(1'b0), .in_data_2('0),
        .flush_req(1'b0), .out_ready(1'b0),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_src(out_src_b),
        .stall(stall_b), .flush(flush_b), .stall_cycles(stall_cycles_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done_sat = 1'b0;

    typedef struct { bit v; bit st; bit fl; int cnt; } stat_t;
    typedef struct { bit src; logic [DW-1:0] d; } xfer_t;

    stat_t         st_q [$];
    xfer_t         sb_q [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    bit            m_last  = 1'b1;
    bit            m_flush = 1'b0;
    int            m_cnt   = 0;
    bit            known   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances from the rules at the same time.
    task automatic cyc(input bit rst_n, input bit v1, input logic [DW-1:0] d1,
                       input bit v2, input logic [DW-1:0] d2, input bit fr, input bit rdy);
        bit    st;
        bit    avail;
        bit    src;
        xfer_t x;
        @(negedge clk);
        #1;
        reset = rst_n; in_valid_1 = v1; in_data_1 = d1;
        in_valid_2 = v2; in_data_2 = d2; flush_req = fr; out_ready = rdy;

        st    = (q1.size() == 2) || (q2.size() == 2);
        avail = ((q1.size() > 0) || (q2.size() > 0)) && !fr;
        if (known) st_q.push_back('{avail, st, m_flush, m_cnt});
        if (known && avail && rdy) begin
            if ((q1.size() > 0) && (q2.size() > 0)) src = !m_last;
            else                                    src = (q2.size() > 0);
            x.src = src;
            x.d   = src ? q2.pop_front() : q1.pop_front();
            sb_q.push_back(x);
            m_last = src;
        end
        if (!rst_n) begin
            q1.delete(); q2.delete();
            m_last = 1'b1; m_flush = 1'b0; m_cnt = 0; known = 1'b1;
        end else begin
            if (!st && !fr) begin
                if (v1) q1.push_back(d1);
                if (v2) q2.push_back(d2);
            end
            if (fr) begin
                q1.delete(); q2.delete();
            end
            m_flush = fr;
            if (st && m_cnt < 65535) m_cnt++;
        end
    endtask

    initial begin : monitor
        stat_t s;
        xfer_t x;
        forever begin
            @(negedge clk);
            #3;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("out_valid", {63'd0, out_valid}, {63'd0, s.v});
                check("stall", {63'd0, stall}, {63'd0, s.st});
                check("flush", {63'd0, flush}, {63'd0, s.fl});
                check("stall_cycles", {48'd0, stall_cycles}, 64'(s.cnt));
                if (!s.v) begin
                    check("idle_data", {32'd0, out_data}, 64'd0);
                    check("idle_src", {63'd0, out_src}, 64'd0);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_xfer: got data %0h src %0d expected no transfer", out_data, out_src);
                end else begin
                    x = sb_q.pop_front();
                    check("out_data", {32'd0, out_data}, {32'd0, x.d});
                    check("out_src", {63'd0, out_src}, {63'd0, x.src});
                end
            end
        end
    end

    initial begin : saturation
        repeat (2) begin @(negedge clk); #1; reset_b = 1'b0; in_valid_1_b = 1'($urandom); end
        @(negedge clk); #1; reset_b = 1'b1; in_valid_1_b = 1'b1; in_data_1_b = 32'd1;
        @(negedge clk); #1; in_data_1_b = 32'd2;
        @(negedge clk); #1; in_valid_1_b = 1'b1; in_data_1_b = 32'd3;
        #3;
        check("sat_full_stall", {63'd0, stall_b}, 64'd1);
        check("sat_cnt0", {60'd0, stall_cycles_b}, 64'd0);
        check("sat_head", {32'd0, out_data_b}, 64'd1);
        repeat (5) @(negedge clk);
        #4;
        check("sat_cnt5", {60'd0, stall_cycles_b}, 64'd5);
        repeat (20) @(negedge clk);
        #4;
        check("sat_cnt15", {60'd0, stall_cycles_b}, 64'd15);
        check("sat_head_kept", {32'd0, out_data_b}, 64'd1);
        @(negedge clk); #1; reset_b = 1'b0;
        @(negedge clk); #1; reset_b = 1'b1; in_valid_1_b = 1'b0;
        #3;
        check("sat_rst_valid", {63'd0, out_valid_b}, 64'd0);
        check("sat_rst_stall", {63'd0, stall_b}, 64'd0);
        check("sat_rst_cnt", {60'd0, stall_cycles_b}, 64'd0);
        done_sat = 1'b1;
    end

    initial begin : stimulus
        bit rn, fr, v1, v2, rdy;
        repeat (2) cyc(0, 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 0);

        cyc(1, 1, 5, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 1);

        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10, 1, 20, 0, 0);
        cyc(1, 1, 11, 1, 21, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0, 0, 1);

        cyc(1, 1, 30, 1, 40, 0, 0);
        cyc(1, 1, 31, 1, 41, 0, 0);
        cyc(1, 1, 99, 0, 0, 1, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 256; i++) cyc(1, 1, 32'(1000 + i), 1, 32'(5000 + i), 0, 1);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 800; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            fr  = ($urandom_range(0, 19) == 0);
            v1  = 1'($urandom);
            v2  = 1'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cyc(rn, v1, $urandom, v2, $urandom, fr, rdy);
        end
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        #5;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        wait (done_sat);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_pipe_stall_ctrl.md
# dual_pipe_stall_ctrl

Global stall/flush controller and output arbiter for the two parallel pipelines in the global-stall design. It accepts the tail-stage outputs of pipeline 1 and pipeline 2 into one 2-entry buffer per lane, merges them onto a single shared downstream valid/ready port with round-robin arbitration, and generates the single global stall and flush that freeze or clear both pipelines together. Stall is derived only from registered state, so there is no combinational path from `out_ready` to the pipelines.

## Interface
- `DATA_W`, 32, data width of each lane and of the output.
- `CNT_W`, 16, width of the saturating stall-cycle counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `in_valid_1`  in  1  pipeline 1 tail valid.
- `in_data_1`  in  DATA_W  pipeline 1 tail data.
- `in_valid_2`  in  1  pipeline 2 tail valid.
- `in_data_2`  in  DATA_W  pipeline 2 tail data.
- `flush_req`  in  1  one-cycle request to flush both pipelines and all buffered data.
- `out_ready`  in  1  downstream sink ready.
- `out_valid`  out  1  output data valid.
- `out_data`  out  DATA_W  head of the granted lane.
- `out_src`  out  1  source of `out_data`: 0 = pipeline 1, 1 = pipeline 2.
- `stall`  out  1  global stall to both pipelines.
- `flush`  out  1  global flush to both pipelines, registered, one cycle.
- `stall_cycles`  out  CNT_W  number of cycles with `stall`=1, saturating.

## Operation
- Each lane has a 2-entry FIFO (`cnt_k` = 0..2), in-order.
- **Stall:** `stall` = (`cnt_1`==2) | (`cnt_2`==2), decoded from registers only.
- **Accept:** lane k writes `in_data_k` when `in_valid_k` & !`stall` & !`flush_req`. While `stall`=1, `in_valid_k` is ignored because the pipelines hold.
- **Arbitration:**
  - Lanes eligible = FIFO non-empty.
  - Exactly one eligible lane is granted.
  - If both are eligible, grant the lane != `last_grant`.
  - `last_grant` updates only on a transfer (`out_valid` & `out_ready`).
- **Output:** `out_valid` = any lane eligible & !`flush_req`. `out_data` and `out_src` come from the granted head. When `out_valid`=0, `out_data`=0 and `out_src`=0.
- **Simultaneous write and drain on the same lane:** the count is unchanged and ordering is preserved. A write into a full lane cannot occur, because stall blocks it.
- **Flush:**
  - `flush_req`=1 empties both FIFOs at the clock edge and drops that cycle's inputs.
  - No transfer occurs that cycle.
  - `flush` = 1 in the following cycle.
  - `last_grant` is not changed.
  - `flush_req` wins over every other event.
- **Counter:** `stall_cycles` increments on every cycle with `stall`=1, saturates at 2^CNT_W-1, and clears only on reset.
- **Reset** (`reset`=0 at an edge), state after the edge:
  - `cnt_1`=`cnt_2`=0.
  - `last_grant`=1, so lane 0 (pipeline 1) wins the first tie.
  - `flush`=0, `stall_cycles`=0.
  - Outputs: `stall`=0, `out_valid`=0, `out_data`=0, `out_src`=0.
  - Reset mid-operation discards all buffered data immediately, and a pending flush pulse is cancelled.

## Timing
- Latency: data accepted at edge t is visible on `out_*` in cycle t+1, giving a minimum of 1 cycle in-to-out.
- `stall` rises in the cycle after the edge that fills a lane to 2. It falls in the cycle after the edge that drains that lane, or after a flush.
- Throughput: one output transfer per cycle maximum. With both lanes streaming and the sink always ready, stall periodically throttles the input to 1 item/cycle on average.
- `flush` is asserted exactly one cycle, the cycle after `flush_req`. Back-to-back `flush_req` gives back-to-back `flush`.
- No combinational path from any input to `stall`, `flush` or `stall_cycles`. `out_valid` depends combinationally on `flush_req` only.

## Test plan
1. **Reset values:** hold reset low for 2 cycles with random inputs. Required: `out_valid`=0, `stall`=0, `flush`=0, `stall_cycles`=0 on the cycle after the first reset edge.
2. **Stall on full lane:** `out_ready`=0; lane 1 presents 5, then 6. Required:
   - `out_valid`=1, `out_data`=5, `out_src`=0 from cycle 2.
   - `stall`=1 from cycle 3.
   - A third value 7 is not accepted.
   - `stall_cycles` counts up while `stall` is high.
   - Raise `out_ready`: outputs are 5, then 6, then `stall` drops.
3. **Round-robin:** preload lane 1 with {10,11} and lane 2 with {20,21}, then `out_ready`=1. Required order: 10(src0), 20(src1), 11(src0), 21(src1).
4. **Flush:** both lanes full and `stall`=1; pulse `flush_req` with `in_valid_1`=1 and `in_data_1`=99. Required:
   - `out_valid`=0 in the flush cycle.
   - Next cycle: `flush`=1, `stall`=0, both lanes empty, 99 never output.
5. **Full-rate streaming:** both lanes valid every cycle with incrementing data and `out_ready`=1 for 256 cycles. Required:
   - Per-lane order preserved; no loss or duplication.
   - Outputs alternate src when both lanes are non-empty.
   - `stall_cycles` equals the number of stalled cycles.
6. **Saturation and reset mid-operation:**
   - `CNT_W`=4, `out_ready`=0, lane 1 full for 20 cycles. Required: `stall_cycles` holds at 15.
   - Then assert reset with the lanes full. Required: empty lanes, `stall`=0, `stall_cycles`=0 next cycle.
